// File: rtl/mod12_pkg.sv
// Shared types and constants for the MOD-12 rollover tracker.
package mod12_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam int MOD12_LAST = 11;
  localparam logic [3:0] RST_TENS = 4'd1;
  localparam logic [3:0] RST_ONES = 4'd2;

endpackage

// File: rtl/mod12_disp_dec.sv
// Combinational count to 12-hour BCD decoder; a count of 0 reads as 12.
module mod12_disp_dec
  import mod12_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] cnt,
  output logic [3:0]    tens,
  output logic [3:0]    ones
);

  always_comb begin
    tens = 4'd0;
    ones = 4'd0;
    if (cnt == '0) begin
      tens = RST_TENS;
      ones = RST_ONES;
    end else if (cnt >= CW'(10)) begin
      tens = 4'd1;
      ones = 4'(cnt - CW'(10));
    end else begin
      ones = 4'(cnt);
    end
  end

endmodule

// File: rtl/mod12_rollover_tracker.sv
// Monitor for a MOD-12 loadable counter: 12-hour display, AM/PM, wrap pulse and fault flags.
// Define MOD12_DAYCNT_EN to add the day_cnt output counting PM->AM rollovers.
//
// state   | meaning
// S_INIT  | first sample after reset, no sequence check
// S_TRACK | checking each transition, outputs live
// S_FAULT | fault latched, outputs frozen until rst
module mod12_rollover_tracker
  import mod12_pkg::*;
#(
  parameter int MOD  = MOD12_LAST + 1,
  parameter int CW   = 4,
  parameter int DAYW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cnt,
  input  logic          ld,
  output logic [3:0]    disp_tens,
  output logic [3:0]    disp_ones,
  output logic          pm,
  output logic          wrap,
  output logic          valid,
  output logic          err_range,
  output logic          err_seq
`ifdef MOD12_DAYCNT_EN
  ,
  output logic [DAYW-1:0] day_cnt
`endif
);

  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] prev_q;
  logic          ld_q;
  logic [CW-1:0] succ;
  logic          out_of_range, seq_bad, wrap_ev, capture;
  logic [3:0]    dec_tens, dec_ones;

  mod12_disp_dec #(.CW(CW)) u_dec (
    .cnt  (cnt),
    .tens (dec_tens),
    .ones (dec_ones)
  );

  always_comb begin
    state_d      = state_q;
    out_of_range = (cnt > LAST);
    seq_bad      = 1'b0;
    wrap_ev      = 1'b0;
    capture      = 1'b0;
    succ         = (prev_q == LAST) ? '0 : prev_q + 1'b1;
    unique case (state_q)
      S_INIT: begin
        if (!out_of_range) begin
          capture = 1'b1;
          state_d = S_TRACK;
        end
      end
      S_TRACK: begin
        // a load accepts any in-range value; a load landing on 0 is not a wrap
        seq_bad = out_of_range || (!ld_q && (cnt != succ));
        if (!seq_bad) begin
          capture = 1'b1;
          wrap_ev = !ld_q && (prev_q == LAST);
        end
      end
      default: ;
    endcase
    if (out_of_range || seq_bad) state_d = S_FAULT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_INIT;
      prev_q    <= '0;
      ld_q      <= 1'b0;
      disp_tens <= RST_TENS;
      disp_ones <= RST_ONES;
      pm        <= 1'b0;
      wrap      <= 1'b0;
      valid     <= 1'b0;
      err_range <= 1'b0;
      err_seq   <= 1'b0;
`ifdef MOD12_DAYCNT_EN
      day_cnt   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ld_q    <= ld;
      valid   <= (state_d == S_TRACK);
      wrap    <= wrap_ev;
      if (out_of_range) err_range <= 1'b1;
      if (seq_bad)      err_seq   <= 1'b1;
      if (capture) begin
        prev_q    <= cnt;
        disp_tens <= dec_tens;
        disp_ones <= dec_ones;
      end
      if (wrap_ev) pm <= ~pm;
`ifdef MOD12_DAYCNT_EN
      if (wrap_ev && pm) day_cnt <= day_cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mod12_rollover_tracker.sv
// Self-checking bench: behavioural counter drives the tracker, a clock-face model predicts outputs.
module tb_mod12_rollover_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld  = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic [3:0] disp_tens, disp_ones;
  logic       pm, wrap, valid, err_range, err_seq;
`ifdef MOD12_DAYCNT_EN
  logic [7:0] day_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // counter model and clock-face reference model
  int ctr = 0;
  int m_prev = 0, m_ldq = 0, m_hour = 12, m_pm = 0, m_wrap = 0;
  int m_tracking = 0, m_fault = 0, m_er = 0, m_es = 0, m_day = 0;
  int wrap_seen = 0;

  always #5 clk = ~clk;

  mod12_rollover_tracker dut (
    .clk       (clk),
    .rst       (rst),
    .cnt       (cnt),
    .ld        (ld),
    .disp_tens (disp_tens),
    .disp_ones (disp_ones),
    .pm        (pm),
    .wrap      (wrap),
    .valid     (valid),
    .err_range (err_range),
    .err_seq   (err_seq)
`ifdef MOD12_DAYCNT_EN
    ,
    .day_cnt   (day_cnt)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_edge(input int r, input int l, input int c);
    int old_ldq;
    bit rng, ok;
    if (r != 0) begin
      m_prev = 0; m_ldq = 0; m_hour = 12; m_pm = 0; m_wrap = 0;
      m_tracking = 0; m_fault = 0; m_er = 0; m_es = 0; m_day = 0;
      return;
    end
    old_ldq = m_ldq;
    m_ldq   = l;
    rng     = (c > 11);
    m_wrap  = 0;
    if (m_fault != 0) begin
      if (rng) m_er = 1;
    end else if (m_tracking == 0) begin
      if (rng) begin
        m_er = 1; m_fault = 1;
      end else begin
        m_prev = c; m_hour = (c == 0) ? 12 : c; m_tracking = 1;
      end
    end else begin
      ok = !rng && ((old_ldq != 0) || (c == (m_prev + 1) % 12));
      if (!ok) begin
        m_es = 1; m_fault = 1; m_tracking = 0;
        if (rng) m_er = 1;
      end else begin
        if (old_ldq == 0 && m_prev == 11) begin
          m_wrap = 1;
          if (m_pm != 0) m_day = (m_day + 1) % 256;
          m_pm = 1 - m_pm;
        end
        m_prev = c; m_hour = (c == 0) ? 12 : c;
      end
    end
  endtask

  // one clock: apply inputs (f>=0 overrides the counter), advance models, compare all outputs
  task automatic step(input int r, input int l, input int din, input int f);
    int c;
    @(negedge clk);
    c   = (f >= 0) ? f : ctr;
    rst = (r != 0);
    ld  = (l != 0);
    cnt = 4'(c);
    @(posedge clk);
    model_edge(r, l, c);
    if (r != 0)      ctr = 0;
    else if (l != 0) ctr = din;
    else             ctr = (ctr + 1) % 12;
    #1;
    if (wrap === 1'b1) wrap_seen++;
    chk("disp_tens", int'(disp_tens), m_hour / 10);
    chk("disp_ones", int'(disp_ones), m_hour % 10);
    chk("pm", int'(pm), m_pm);
    chk("wrap", int'(wrap), m_wrap);
    chk("valid", int'(valid), (m_tracking != 0 && m_fault == 0) ? 1 : 0);
    chk("err_range", int'(err_range), m_er);
    chk("err_seq", int'(err_seq), m_es);
`ifdef MOD12_DAYCNT_EN
    chk("day_cnt", int'(day_cnt), m_day);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, -1);
  endtask

  initial begin
    // reset values
    step(1, 0, 0, -1);
    chk("rst_tens", int'(disp_tens), 1);
    chk("rst_ones", int'(disp_ones), 2);

    // free run 14 clocks: 12,01..11,12,01 with one wrap
    wrap_seen = 0;
    run(14);
    chk("free_wraps", wrap_seen, 1);
    chk("free_pm", int'(pm), 1);
    chk("free_valid", int'(valid), 1);

    // load 5 while the counter shows 2
    step(1, 0, 0, -1);
    run(2);
    step(0, 1, 5, -1);
    step(0, 0, 0, -1);
    chk("load_ones", int'(disp_ones), 5);
    run(2);
    chk("load_cont", int'(disp_ones), 7);
    chk("load_seq", int'(err_seq), 0);

    // load to 0 from 11 is not a wrap
    run(3);
    step(0, 1, 0, -1);
    step(0, 0, 0, -1);
    chk("ld0_wrap", int'(wrap), 0);
    chk("ld0_pm", int'(pm), 0);

    // sequence fault 3 -> 7
    step(1, 0, 0, -1);
    run(4);
    step(0, 0, 0, 7);
    chk("seq_err", int'(err_seq), 1);
    chk("seq_valid", int'(valid), 0);
    run(5);
    chk("seq_frozen", int'(disp_ones), 3);

    // range fault, then reset clears it
    step(1, 0, 0, -1);
    run(2);
    step(0, 0, 0, 13);
    chk("rng_err", int'(err_range), 1);
    run(2);
    step(1, 0, 0, -1);
    chk("rng_clr", int'(err_range), 0);
    chk("rng_disp", int'(disp_tens) * 10 + int'(disp_ones), 12);

    // two full cycles: pm 0->1->0, one day elapsed
    run(25);
    chk("two_pm", int'(pm), 0);
`ifdef MOD12_DAYCNT_EN
    chk("two_day", int'(day_cnt), 1);
`endif

    // reset at cnt=8, then clean tracking resumes
    step(1, 0, 0, -1);
    run(8);
    step(1, 0, 0, -1);
    chk("mid_valid", int'(valid), 0);
    run(6);
    chk("mid_noerr", int'(err_seq) + int'(err_range), 0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int r, l, d, f, sel;
      r   = ($urandom_range(0, 59) == 0) ? 1 : 0;
      l   = ($urandom_range(0, 5) == 0) ? 1 : 0;
      d   = int'($urandom_range(0, 11));
      sel = int'($urandom_range(0, 149));
      f   = -1;
      if (sel == 0)      f = int'($urandom_range(12, 15));
      else if (sel == 1) f = int'($urandom_range(0, 11));
      step(r, l, d, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
